// File: rtl/xadac_pkg.sv
// Shared xadac types and constants: request/response payloads plus the vector
// scoreboard slot record and its default sizing.
package xadac_pkg;

    localparam int NoVs      = 3;
    localparam int VecAddrW  = 5;
    localparam int IdW       = 4;
    localparam int InstrW    = 32;
    localparam int DataW     = 32;
    localparam int VdLsb     = 7;
    localparam int VsbNoIds  = 4;
    localparam int VsbCntW   = 2;

    typedef logic [VecAddrW-1:0] VecAddrT;
    typedef logic [IdW-1:0]      IdT;

    typedef struct packed {
        IdT                id;
        logic [InstrW-1:0] instr;
    } DecReqT;

    typedef struct packed {
        IdT   id;
        logic accept;
        logic is_vec;
    } DecRspT;

    typedef struct packed {
        IdT                     id;
        logic [InstrW-1:0]      instr;
        VecAddrT [NoVs-1:0]     vs_addr;
    } ExeReqT;

    typedef struct packed {
        IdT               id;
        VecAddrT          vd_addr;
        logic [DataW-1:0] vd_data;
        logic             vd_write;
    } ExeRspT;

    typedef struct packed {
        logic    valid;
        VecAddrT vd;
    } VsbSlotT;

    function automatic VecAddrT instr_vd(input logic [InstrW-1:0] instr);
        return instr[VdLsb +: VecAddrW];
    endfunction

endpackage

// File: rtl/xadac_if.sv
// xadac handshake bundle: decode and exe channels, each a valid/ready request
// plus a valid/ready response. mst drives requests, slv drives responses.
interface xadac_if;
    import xadac_pkg::*;

    DecReqT dec_req;
    logic   dec_req_valid;
    logic   dec_req_ready;
    DecRspT dec_rsp;
    logic   dec_rsp_valid;
    logic   dec_rsp_ready;
    ExeReqT exe_req;
    logic   exe_req_valid;
    logic   exe_req_ready;
    ExeRspT exe_rsp;
    logic   exe_rsp_valid;
    logic   exe_rsp_ready;

    modport mst (
        output dec_req, dec_req_valid, dec_rsp_ready,
        output exe_req, exe_req_valid, exe_rsp_ready,
        input  dec_req_ready, dec_rsp, dec_rsp_valid,
        input  exe_req_ready, exe_rsp, exe_rsp_valid
    );

    modport slv (
        input  dec_req, dec_req_valid, dec_rsp_ready,
        input  exe_req, exe_req_valid, exe_rsp_ready,
        output dec_req_ready, dec_rsp, dec_rsp_valid,
        output exe_req_ready, exe_rsp, exe_rsp_valid
    );

endinterface

// File: rtl/xadac_vsb_cnt.sv
// Per-register pending-write counters. An increment and a decrement hitting the
// same register in one cycle cancel out; counters neither wrap nor underflow.
module xadac_vsb_cnt #(
    parameter int NoVecRegs = 32,
    parameter int CntW      = 2,
    parameter int AddrW     = $clog2(NoVecRegs)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 inc_en,
    input  logic [AddrW-1:0]     inc_addr,
    input  logic                 dec_en,
    input  logic [AddrW-1:0]     dec_addr,
    output logic [NoVecRegs-1:0] pending,
    output logic [NoVecRegs-1:0] full
);

    localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};
    localparam logic [CntW-1:0] CntOne = CntW'(1'b1);

    logic [CntW-1:0]      cnt_r [NoVecRegs];
    logic [NoVecRegs-1:0] inc_hit_s;
    logic [NoVecRegs-1:0] dec_hit_s;

    // Status flags and guarded per-register update strobes
    always_comb begin
        pending   = '0;
        full      = '0;
        inc_hit_s = '0;
        dec_hit_s = '0;
        for (int r = 0; r < NoVecRegs; r++) begin
            pending[r]   = (cnt_r[r] != '0);
            full[r]      = (cnt_r[r] == CntMax);
            inc_hit_s[r] = inc_en && (inc_addr == AddrW'(r)) && (cnt_r[r] != CntMax);
            dec_hit_s[r] = dec_en && (dec_addr == AddrW'(r)) && (cnt_r[r] != '0);
        end
    end

    // Counter array update
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < NoVecRegs; r++) begin
                cnt_r[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NoVecRegs; r++) begin
                if (inc_hit_s[r] && !dec_hit_s[r]) begin
                    cnt_r[r] <= cnt_r[r] + CntOne;
                end else if (dec_hit_s[r] && !inc_hit_s[r]) begin
                    cnt_r[r] <= cnt_r[r] - CntOne;
                end else begin
                    cnt_r[r] <= cnt_r[r];
                end
            end
        end
    end

endmodule

// File: rtl/xadac_vsb.sv
// Vector scoreboard in front of the VRF: stalls exe requests that would read or
// overwrite a register with an outstanding write. Optional XADAC_VSB_PERF_EN adds stall_cnt.
module xadac_vsb
    import xadac_pkg::*;
#(
    parameter int NoIds     = VsbNoIds,
    parameter int CntW      = VsbCntW,
    parameter int NoVecRegs = 32
) (
    input  logic        clk,
    input  logic        rstn,
    xadac_if.slv        slv,
    xadac_if.mst        mst,
    output logic        busy,
    output logic        err
`ifdef XADAC_VSB_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int IdxW = (NoIds > 1) ? $clog2(NoIds) : 1;

    VsbSlotT              slot_r [NoIds];
    logic                 err_r;
    logic [IdxW-1:0]      req_idx_s;
    logic [IdxW-1:0]      rsp_idx_s;
    VecAddrT              req_vd_s;
    VecAddrT              rsp_vd_s;
    logic                 src_hit_s;
    logic                 hazard_s;
    logic                 acc_s;
    logic                 rsp_hs_s;
    logic                 rsp_hit_s;
    logic [NoVecRegs-1:0] pending_s;
    logic [NoVecRegs-1:0] full_s;

    assign mst.dec_req       = slv.dec_req;
    assign mst.dec_req_valid = slv.dec_req_valid;
    assign slv.dec_req_ready = mst.dec_req_ready;
    assign slv.dec_rsp       = mst.dec_rsp;
    assign slv.dec_rsp_valid = mst.dec_rsp_valid;
    assign mst.dec_rsp_ready = slv.dec_rsp_ready;

    assign mst.exe_req       = slv.exe_req;
    assign mst.exe_req_valid = slv.exe_req_valid & ~hazard_s;
    assign slv.exe_req_ready = mst.exe_req_ready & ~hazard_s;
    assign slv.exe_rsp       = mst.exe_rsp;
    assign slv.exe_rsp_valid = mst.exe_rsp_valid;
    assign mst.exe_rsp_ready = slv.exe_rsp_ready;

    assign req_idx_s = slv.exe_req.id[IdxW-1:0];
    assign req_vd_s  = instr_vd(slv.exe_req.instr);
    assign rsp_idx_s = mst.exe_rsp.id[IdxW-1:0];
    assign rsp_hit_s = slot_r[rsp_idx_s].valid;
    assign rsp_vd_s  = slot_r[rsp_idx_s].vd;
    assign acc_s     = slv.exe_req_valid & ~hazard_s & mst.exe_req_ready;
    assign rsp_hs_s  = mst.exe_rsp_valid & mst.exe_rsp_ready;
    assign err       = err_r;

    // Hazard from registered state only: a response this cycle frees nothing until the next
    always_comb begin
        src_hit_s = 1'b0;
        for (int i = 0; i < NoVs; i++) begin
            src_hit_s = src_hit_s | pending_s[slv.exe_req.vs_addr[i]];
        end
        hazard_s = src_hit_s | pending_s[req_vd_s] | full_s[req_vd_s] |
                   slot_r[req_idx_s].valid;
    end

    // busy reflects any occupied id slot
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NoIds; i++) begin
            busy = busy | slot_r[i].valid;
        end
    end

    xadac_vsb_cnt #(
        .NoVecRegs (NoVecRegs),
        .CntW      (CntW),
        .AddrW     (VecAddrW)
    ) u_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .inc_en   (acc_s),
        .inc_addr (req_vd_s),
        .dec_en   (rsp_hs_s & rsp_hit_s),
        .dec_addr (rsp_vd_s),
        .pending  (pending_s),
        .full     (full_s)
    );

    // Slot table and sticky error; a valid slot can never be re-accepted, so set and clear never collide
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NoIds; i++) begin
                slot_r[i] <= '0;
            end
            err_r <= 1'b0;
        end else begin
            for (int i = 0; i < NoIds; i++) begin
                if (acc_s && (req_idx_s == IdxW'(i))) begin
                    slot_r[i] <= '{valid: 1'b1, vd: req_vd_s};
                end else if (rsp_hs_s && rsp_hit_s && (rsp_idx_s == IdxW'(i))) begin
                    slot_r[i].valid <= 1'b0;
                end else begin
                    slot_r[i] <= slot_r[i];
                end
            end
            if (rsp_hs_s && !rsp_hit_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

`ifdef XADAC_VSB_PERF_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles a valid request is held back
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_r <= 32'd0;
        end else if (slv.exe_req_valid && hazard_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_xadac_vsb.sv
// Randomized self-checking bench for xadac_vsb against a queue-based model of
// outstanding writes; build with XADAC_VSB_PERF_EN to also check stall_cnt.
module tb_xadac_vsb;
    import xadac_pkg::*;

    logic clk;
    logic rstn;
    logic busy;
    logic err;
`ifdef XADAC_VSB_PERF_EN
    logic [31:0] stall_cnt;
`endif

    xadac_if core_if ();
    xadac_if vrf_if ();

    xadac_vsb dut (
        .clk       (clk),
        .rstn      (rstn),
        .slv       (core_if),
        .mst       (vrf_if),
        .busy      (busy),
        .err       (err)
`ifdef XADAC_VSB_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int id;
        int vd;
    } out_t;

    out_t    outq[$];
    bit      m_err;
    longint  m_stall;
    int      n_vec;
    int      n_err;
    ExeRspT  no_rsp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pend_cnt(input int r);
        int n = 0;
        foreach (outq[k]) if (outq[k].vd == r) n++;
        return n;
    endfunction

    function automatic bit slot_busy(input int idx);
        foreach (outq[k]) if (outq[k].idx == idx) return 1'b1;
        return 1'b0;
    endfunction

    // A request must wait while anything it touches has a write in flight or its id is in use
    function automatic bit model_hazard(input ExeReqT q);
        int vd = int'(q.instr[11:7]);
        bit h  = 1'b0;
        for (int i = 0; i < NoVs; i++) if (pend_cnt(int'(q.vs_addr[i])) > 0) h = 1'b1;
        if (pend_cnt(vd) > 0) h = 1'b1;
        if (pend_cnt(vd) >= 3) h = 1'b1;
        if (slot_busy(int'(q.id) % VsbNoIds)) h = 1'b1;
        return h;
    endfunction

    function automatic ExeReqT mk_req(input int id, input int vd, input int s0, input int s1, input int s2);
        ExeReqT q;
        q.id         = IdT'(id);
        q.instr      = $urandom;
        q.instr[11:7] = VecAddrT'(vd);
        q.vs_addr[0] = VecAddrT'(s0);
        q.vs_addr[1] = VecAddrT'(s1);
        q.vs_addr[2] = VecAddrT'(s2);
        return q;
    endfunction

    function automatic ExeRspT mk_rsp(input int id, input bit wr);
        ExeRspT r;
        r.id       = IdT'(id);
        r.vd_addr  = VecAddrT'($urandom);
        r.vd_data  = $urandom;
        r.vd_write = wr;
        return r;
    endfunction

    task automatic step(input bit rq_v, input ExeReqT rq, input bit vrf_rdy,
                        input bit rs_v, input ExeRspT rs, input bit core_rdy);
        DecReqT dq;
        DecRspT ds;
        bit     dv, dr, sv, sr, hz, acc, hs;
        int     hit;
        @(negedge clk);
        dq = DecReqT'({$urandom, $urandom});
        ds = DecRspT'($urandom);
        dv = 1'($urandom); dr = 1'($urandom); sv = 1'($urandom); sr = 1'($urandom);
        core_if.dec_req       = dq;
        core_if.dec_req_valid = dv;
        core_if.dec_rsp_ready = sr;
        vrf_if.dec_req_ready  = dr;
        vrf_if.dec_rsp        = ds;
        vrf_if.dec_rsp_valid  = sv;
        core_if.exe_req       = rq;
        core_if.exe_req_valid = rq_v;
        vrf_if.exe_req_ready  = vrf_rdy;
        vrf_if.exe_rsp        = rs;
        vrf_if.exe_rsp_valid  = rs_v;
        core_if.exe_rsp_ready = core_rdy;
        #1;
        hz = model_hazard(rq);
        check("busy",          64'(busy),                  64'(outq.size() != 0));
        check("err",           64'(err),                   64'(m_err));
        check("exe_req_valid", 64'(vrf_if.exe_req_valid),  64'(rq_v & ~hz));
        check("exe_req_ready", 64'(core_if.exe_req_ready), 64'(vrf_rdy & ~hz));
        check("exe_req_pass",  64'(vrf_if.exe_req),        64'(rq));
        check("exe_rsp_pass",  64'(core_if.exe_rsp),       64'(rs));
        check("exe_rsp_valid", 64'(core_if.exe_rsp_valid), 64'(rs_v));
        check("exe_rsp_ready", 64'(vrf_if.exe_rsp_ready),  64'(core_rdy));
        check("dec_req_pass",  64'({vrf_if.dec_req, vrf_if.dec_req_valid}), 64'({dq, dv}));
        check("dec_req_ready", 64'(core_if.dec_req_ready), 64'(dr));
        check("dec_rsp_pass",  64'({core_if.dec_rsp, core_if.dec_rsp_valid}), 64'({ds, sv}));
        check("dec_rsp_ready", 64'(vrf_if.dec_rsp_ready),  64'(sr));
`ifdef XADAC_VSB_PERF_EN
        check("stall_cnt",     64'(stall_cnt),             64'(m_stall));
`endif
        acc = rq_v & ~hz & vrf_rdy;
        hs  = rs_v & core_rdy;
        @(posedge clk);
        if (hs) begin
            hit = -1;
            foreach (outq[k]) if (outq[k].idx == int'(rs.id) % VsbNoIds) hit = k;
            if (hit >= 0) outq.delete(hit);
            else m_err = 1'b1;
        end
        if (acc) outq.push_back('{idx: int'(rq.id) % VsbNoIds, id: int'(rq.id), vd: int'(rq.instr[11:7])});
        if (rq_v && hz && m_stall < 64'hFFFF_FFFF) m_stall++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        core_if.exe_req_valid = 1'b0;
        vrf_if.exe_rsp_valid  = 1'b0;
        rstn = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_err",  64'(err),  64'(0));
        outq.delete();
        m_err   = 1'b0;
        m_stall = 0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic rand_steps(input int n, input int reg_span);
        ExeReqT q;
        ExeRspT r;
        int     k;
        for (int c = 0; c < n; c++) begin
            q = mk_req($urandom_range(15), $urandom_range(reg_span - 1), $urandom_range(reg_span - 1),
                       $urandom_range(reg_span - 1), $urandom_range(reg_span - 1));
            if (outq.size() != 0 && $urandom_range(7) != 0) begin
                k = $urandom_range(outq.size() - 1);
                r = mk_rsp(outq[k].id, 1'($urandom));
            end else begin
                r = mk_rsp($urandom_range(15), 1'($urandom));
            end
            step(1'($urandom_range(3) != 0), q, 1'($urandom_range(3) != 0),
                 1'($urandom_range(2) == 0), r, 1'($urandom_range(3) != 0));
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        m_err   = 1'b0;
        m_stall = 0;
        no_rsp  = mk_rsp(0, 1'b0);
        rstn    = 1'b0;
        core_if.exe_req_valid = 1'b0;
        vrf_if.exe_rsp_valid  = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // independent back-to-back, then RAW on v5 released one cycle after the response
        step(1'b1, mk_req(0, 1, 3, 4, 3), 1'b1, 1'b0, no_rsp, 1'b1);
        step(1'b1, mk_req(1, 2, 3, 4, 4), 1'b1, 1'b0, no_rsp, 1'b1);
        step(1'b1, mk_req(2, 5, 0, 0, 0), 1'b1, 1'b0, no_rsp, 1'b1);
        repeat (5) step(1'b1, mk_req(3, 9, 5, 8, 8), 1'b1, 1'b0, no_rsp, 1'b1);
`ifdef XADAC_VSB_PERF_EN
        check("stall_cnt_5", 64'(stall_cnt), 64'(5));
`endif
        step(1'b1, mk_req(3, 9, 5, 8, 8), 1'b1, 1'b1, mk_rsp(2, 1'b1), 1'b1);
        step(1'b1, mk_req(3, 9, 5, 8, 8), 1'b1, 1'b0, no_rsp, 1'b1);
        // WAW on v2 and id reuse (id5 aliases slot 1)
        step(1'b1, mk_req(2, 2, 10, 10, 10), 1'b1, 1'b0, no_rsp, 1'b1);
        step(1'b1, mk_req(5, 11, 10, 10, 10), 1'b1, 1'b0, no_rsp, 1'b1);
        step(1'b1, mk_req(5, 11, 10, 10, 10), 1'b1, 1'b1, mk_rsp(1, 1'b0), 1'b1);
        step(1'b1, mk_req(5, 11, 10, 10, 10), 1'b1, 1'b0, no_rsp, 1'b1);
        // non-writing response still frees, then a spurious one sets err
        step(1'b0, mk_req(0, 0, 0, 0, 0), 1'b1, 1'b1, mk_rsp(3, 1'b0), 1'b1);
        step(1'b1, mk_req(7, 9, 12, 12, 12), 1'b1, 1'b1, mk_rsp(2, 1'b1), 1'b1);
        step(1'b0, mk_req(0, 0, 0, 0, 0), 1'b1, 1'b0, no_rsp, 1'b1);
        do_reset();
        step(1'b1, mk_req(1, 1, 9, 11, 9), 1'b1, 1'b1, mk_rsp(7, 1'b1), 1'b1);

        rand_steps(600, 8);
        do_reset();
        rand_steps(400, 32);
        do_reset();
        rand_steps(300, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
